// File: rtl/time_counter.sv
// time_counter: free-running cycle counter for measuring datapath latency.
// Counts rising edges of clk from the end of reset. A high stop input freezes
// the count so it can be read out. Reports whether it advanced on the last
// edge (running) and a sticky overflow flag.
// Build option: define TIME_COUNTER_SAT_EN to make the count saturate at its
// maximum instead of wrapping to zero.
module time_counter #(
  parameter int WIDTH = 32  // legal range 2..64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stop,
  output logic [WIDTH-1:0] ticks,
  output logic             running,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             at_max;
  logic             hold;
  logic             en;
  logic [WIDTH-1:0] ticks_nxt;
  logic             running_nxt;
  logic             overflow_nxt;

  assign at_max = (ticks == MAX);

`ifdef TIME_COUNTER_SAT_EN
  // Once the overflow flag is up the count is pinned at max; further edges
  // are not counted and running drops, even with stop low.
  assign hold = overflow;
`else
  // Wrapping build never stalls on its own.
  assign hold = 1'b0;
`endif

  // Reset priority lives in the register process; here only stop and the
  // saturation stall gate counting.
  assign en = !stop && !hold;

  // Next-state values for a non-reset edge.
  always_comb begin
    ticks_nxt    = ticks;
    running_nxt  = 1'b0;
    overflow_nxt = overflow;
    if (en) begin
      running_nxt = 1'b1;
      if (at_max) begin
        // The wrap (or the saturating hit) and the overflow set share one edge.
        overflow_nxt = 1'b1;
`ifdef TIME_COUNTER_SAT_EN
        ticks_nxt    = MAX;
`else
        ticks_nxt    = '0;
`endif
      end else begin
        ticks_nxt = ticks + ONE;
      end
    end
  end

  // State registers; synchronous reset clears everything and overrides stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ticks    <= '0;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      ticks    <= ticks_nxt;
      running  <= running_nxt;
      overflow <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter: a default-width and a 4-bit instance
// share rst/stop. A count-of-enabled-edges model predicts all outputs.
module tb_time_counter;

`ifdef TIME_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stop = 1'b0;
  logic [31:0] t32;
  logic        run32, ovf32;
  logic [3:0]  t4;
  logic        run4, ovf4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  time_counter dut32 (
    .clk(clk), .rst(rst), .stop(stop),
    .ticks(t32), .running(run32), .overflow(ovf32)
  );

  time_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .stop(stop),
    .ticks(t4), .running(run4), .overflow(ovf4)
  );

  // Model: n = number of non-reset, non-stopped edges since the last reset
  // (capped far above any width tested); last_cnt = previous edge was one.
  logic [63:0] n = 64'd0;
  bit          last_cnt = 1'b0;
  bit          armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      n        <= 64'd0;
      last_cnt <= 1'b0;
      armed    <= 1'b1;
    end else if (stop) begin
      last_cnt <= 1'b0;
    end else begin
      last_cnt <= 1'b1;
      if (n < 64'd1 << 40) n <= n + 64'd1;
    end
  end

  function automatic logic [63:0] mx(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] exp_ticks(input int w);
    if (SAT) return (n > mx(w)) ? mx(w) : n;
    return n & mx(w);
  endfunction

  function automatic logic exp_ovf(input int w);
    return n > mx(w);
  endfunction

  // Saturating build: the edge that hits max still counts as advancing,
  // every later counted edge does not.
  function automatic logic exp_run(input int w);
    if (SAT) return last_cnt && (n <= mx(w) + 64'd1);
    return last_cnt;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous model comparison, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("m_ticks32", 64'(t32), exp_ticks(32));
      chk("m_run32",   64'(run32), 64'(exp_run(32)));
      chk("m_ovf32",   64'(ovf32), 64'(exp_ovf(32)));
      chk("m_ticks4",  64'(t4), exp_ticks(4));
      chk("m_run4",    64'(run4), 64'(exp_run(4)));
      chk("m_ovf4",    64'(ovf4), 64'(exp_ovf(4)));
    end
  end

  task automatic step(input logic r, input logic s, input int cnt);
    rst  = r;
    stop = s;
    repeat (cnt) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset then count
    step(1, 0, 2);
    chk("rst_ticks", 64'(t32), 64'd0);
    chk("rst_run",   64'(run32), 64'd0);
    chk("rst_ovf",   64'(ovf32), 64'd0);
    step(0, 0, 5);
    chk("cnt5_ticks", 64'(t32), 64'd5);
    chk("cnt5_run",   64'(run32), 64'd1);
    chk("cnt5_ovf",   64'(ovf32), 64'd0);

    // Stop hold
    step(0, 0, 2);
    chk("cnt7_ticks", 64'(t32), 64'd7);
    step(0, 1, 1);
    chk("stop1_ticks", 64'(t32), 64'd7);
    chk("stop1_run",   64'(run32), 64'd0);
    step(0, 1, 9);
    chk("stop10_ticks", 64'(t32), 64'd7);
    step(0, 0, 3);
    chk("resume_ticks", 64'(t32), 64'd10);
    chk("resume_run",   64'(run32), 64'd1);

    // Priority: rst beats stop, then stop held after rst falls
    step(1, 1, 3);
    chk("pri_ticks", 64'(t32), 64'd0);
    chk("pri_run",   64'(run32), 64'd0);
    step(0, 1, 2);
    chk("pri_hold_ticks", 64'(t32), 64'd0);
    chk("pri_hold_run",   64'(run32), 64'd0);

    // Reset mid-count
    step(0, 0, 12);
    chk("cnt12_ticks", 64'(t32), 64'd12);
    step(1, 0, 1);
    chk("midrst_ticks", 64'(t32), 64'd0);
    step(0, 0, 1);
    chk("after_rst_ticks", 64'(t32), 64'd1);

    // Overflow / saturation on the 4-bit instance
    step(1, 0, 1);
    step(0, 0, 15);
    chk("w4_15_ticks", 64'(t4), 64'd15);
    chk("w4_15_ovf",   64'(ovf4), 64'd0);
    step(0, 0, 1);
    chk("w4_16_ticks", 64'(t4), SAT ? 64'd15 : 64'd0);
    chk("w4_16_ovf",   64'(ovf4), 64'd1);
    chk("w4_16_run",   64'(run4), 64'd1);
    chk("w32_16_ovf",  64'(ovf32), 64'd0);
    step(0, 0, 1);
    chk("w4_17_run",   64'(run4), SAT ? 64'd0 : 64'd1);
    step(0, 0, 4);
    chk("w4_21_ticks", 64'(t4), SAT ? 64'd15 : 64'd5);
    chk("w4_21_ovf",   64'(ovf4), 64'd1);
    chk("w4_21_run",   64'(run4), SAT ? 64'd0 : 64'd1);
    chk("w32_21_ticks", 64'(t32), 64'd21);
    step(1, 0, 1);
    chk("w4_rst_ovf",   64'(ovf4), 64'd0);
    chk("w4_rst_ticks", 64'(t4), 64'd0);

    // Randomized traffic: rare resets, frequent stop toggles, long runs
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      stop = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
    end

    step(0, 0, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
